// File: rtl/mm_pkg.sv
// Shared types and widths for the 5x2 by 2x4 matrix-multiply scheduler.
package mm_pkg;

  localparam int unsigned MM_ELEM_W = 12;
  localparam int unsigned MM_A_W    = 10 * MM_ELEM_W;
  localparam int unsigned MM_B_W    = 8 * MM_ELEM_W;
  localparam int unsigned MM_C_W    = 20 * MM_ELEM_W;
  localparam int unsigned MM_CNT_W  = 4;
  localparam int unsigned MM_JOBS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_e;

  typedef logic mm_id_t;

  // Operand payload carried from a requester to the datapath
  typedef struct packed {
    logic [MM_A_W-1:0] a;
    logic [MM_B_W-1:0] b;
  } mm_ops_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; ptr selects the winner only when both request.
module rr_arb2
  import mm_pkg::*;
(
  input  logic [1:0] req,
  input  mm_id_t     ptr,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mat_mul_sched.sv
// Scheduler/sequencer for the shared matrix-multiply datapath.
// Optional job counter enabled by defining MM_SCHED_STATS_EN.
module mat_mul_sched
  import mm_pkg::*;
#(
  parameter int unsigned MM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [MM_A_W-1:0] req0_a,
  input  logic [MM_B_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [MM_A_W-1:0] req1_a,
  input  logic [MM_B_W-1:0] req1_b,
  output logic [MM_A_W-1:0] mm_a,
  output logic [MM_B_W-1:0] mm_b,
  input  logic [MM_C_W-1:0] mm_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MM_C_W-1:0] res_c,
  output mm_id_t            res_id
`ifdef MM_SCHED_STATS_EN
  ,
  output logic [MM_JOBS_W-1:0] job_cnt
`endif
);

  mm_state_e             state_q, state_d;
  mm_id_t                rr_q, rr_d;
  logic [MM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MM_A_W-1:0]     mm_a_d;
  logic [MM_B_W-1:0]     mm_b_d;
  logic [MM_C_W-1:0]     res_c_d;
  mm_id_t                res_id_d;
  logic                  res_valid_d;
  logic [1:0]            gnt_c;
  mm_ops_t               req0_ops, req1_ops, win_ops;

  assign req0_ops = '{a: req0_a, b: req0_b};
  assign req1_ops = '{a: req1_a, b: req1_b};
  assign win_ops  = gnt_c[1] ? req1_ops : req0_ops;

  rr_arb2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .ptr   (rr_q),
    .gnt_c (gnt_c)
  );

  // State and datapath-facing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      mm_a      <= '0;
      mm_b      <= '0;
      res_c     <= '0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      mm_a      <= mm_a_d;
      mm_b      <= mm_b_d;
      res_c     <= res_c_d;
      res_id    <= res_id_d;
      res_valid <= res_valid_d;
    end
  end

  // Next-state and handshake logic; ready is only offered in IDLE
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mm_a_d      = mm_a;
    mm_b_d      = mm_b;
    res_c_d     = res_c;
    res_id_d    = res_id;
    res_valid_d = res_valid;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = gnt_c[0];
        req1_ready = gnt_c[1];
        if (|gnt_c) begin
          mm_a_d   = win_ops.a;
          mm_b_d   = win_ops.b;
          res_id_d = gnt_c[1];
          rr_d     = ~gnt_c[1];
          cnt_d    = MM_CNT_W'(MM_LAT);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          res_c_d     = mm_c;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - MM_CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MM_SCHED_STATS_EN
  // Completed-job counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt <= '0;
    end else if (res_valid && res_ready) begin
      job_cnt <= job_cnt + MM_JOBS_W'(1);
    end
  end
`endif

endmodule
